spi_master_ctrl: RTL and testbench

Parametrised SPI master engine that drives the SPI bus signals (sclk, mosi, miso, ss_n) from a valid/ready word interface. It generalises the existing single-slave SPI signal set to configurable word width, multiple slave selects, all four CPOL/CPHA modes and a programmable SCLK divider. It sits between the bus-facing register block and the pads, and the SPI VIP bench drives it.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_master_ctrl_if.sv | 46 ++++
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_master_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI master controller.
// Mode encodings are {cpol, cpha}.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic int ss_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: word handshake plus SPI pin bundle for spi_master_ctrl.
// SPI_MASTER_LOOPBACK_EN adds the loopback request bit.
interface spi_master_ctrl_if
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8
);
   localparam int SS_W = ss_w(NUM_SS);

   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [SS_W-1:0]   tx_ss_sel;
   logic              cpol;
   logic              cpha;
   logic [DIV_W-1:0]  clk_div;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [NUM_SS-1:0] ss_n;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic              loopback;
`endif

   modport master (
      output tx_valid, tx_data, tx_ss_sel, cpol, cpha, clk_div, miso,
`ifdef SPI_MASTER_LOOPBACK_EN
      output loopback,
`endif
      input  tx_ready, rx_valid, rx_data, busy, sclk, mosi, ss_n
   );

   modport slave (
      input  tx_valid, tx_data, tx_ss_sel, cpol, cpha, clk_div, miso,
`ifdef SPI_MASTER_LOOPBACK_EN
      input  loopback,
`endif
      output tx_ready, rx_valid, rx_data, busy, sclk, mosi, ss_n
   );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer and SCLK edge counter; tick marks the end of
// every H-cycle interval, the edge pulses only fire while transferring.
module spi_clk_gen #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             xfer,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             lead_pulse,
   output logic             trail_pulse,
   output logic             last_edge
);
   localparam int EW = $clog2(2 * DATA_W + 1);

   logic [DIV_W-1:0] cnt;
   logic [EW-1:0]    ecnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         ecnt <= '0;
      end else begin
         cnt  <= (!en || tick) ? '0 : cnt + 1'b1;
         ecnt <= !xfer ? '0 : (tick ? ecnt + 1'b1 : ecnt);
      end
   end

   // Even edge indices are leading edges, odd ones trailing.
   assign tick        = en && (cnt == div);
   assign lead_pulse  = tick && xfer && !ecnt[0];
   assign trail_pulse = tick && xfer && ecnt[0];
   assign last_edge   = tick && xfer && (ecnt == EW'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master engine, all four modes, programmable divider,
// NUM_SS selects; SPI_MASTER_LOOPBACK_EN samples the internal mosi instead of miso.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8
) (
   input logic           clk,
   input logic           rst_n,
   spi_master_ctrl_if.slave bus
);
   localparam int SS_W = ss_w(NUM_SS);

   spi_state_e        state;
   logic [DATA_W-1:0] tx_sh, rx_sh, rx_data_q;
   logic [DIV_W-1:0]  div_q;
   logic [NUM_SS-1:0] ss_n_q;
   logic              cpol_q, cpha_q;
   logic              tx_ready_q, busy_q, rx_valid_q, sclk_q, mosi_q;
   logic              tick, lead, trail, last;
   logic              sample_bit, drive_en, sample_en;

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
      for (int i = 0; i < NUM_SS; i++) ss_decode[i] = (int'(sel) != i);
   endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
   logic lb_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lb_q <= 1'b0;
      else if (state == IDLE && bus.tx_valid) lb_q <= bus.loopback;
   end
   assign sample_bit = lb_q ? mosi_q : bus.miso;
`else
   assign sample_bit = bus.miso;
`endif

   spi_clk_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_clk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (state != IDLE),
      .xfer       (state == XFER),
      .div        (div_q),
      .tick       (tick),
      .lead_pulse (lead),
      .trail_pulse(trail),
      .last_edge  (last)
   );

   // cpha=0 drives on trailing edges (not after the final one), cpha=1 on leading.
   assign drive_en  = cpha_q ? lead : (trail && !last);
   assign sample_en = cpha_q ? trail : lead;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ss_n_q     <= '1;
         tx_sh      <= '0;
         rx_sh      <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         div_q      <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               sclk_q <= bus.cpol;
               mosi_q <= 1'b0;
               if (bus.tx_valid) begin
                  state      <= SETUP;
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cpol_q     <= bus.cpol;
                  cpha_q     <= bus.cpha;
                  div_q      <= bus.clk_div;
                  ss_n_q     <= ss_decode(bus.tx_ss_sel);
                  tx_sh      <= bus.cpha ? bus.tx_data : bus.tx_data << 1;
                  mosi_q     <= bus.cpha ? 1'b0 : bus.tx_data[DATA_W-1];
                  rx_sh      <= '0;
               end
            end
            SETUP: if (tick) state <= XFER;
            XFER: begin
               if (tick) sclk_q <= last ? cpol_q : ~sclk_q;
               if (drive_en) begin
                  mosi_q <= tx_sh[DATA_W-1];
                  tx_sh  <= tx_sh << 1;
               end
               if (sample_en) rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
               if (last) state <= HOLD;
            end
            HOLD: if (tick) begin
               state      <= IDLE;
               ss_n_q     <= '1;
               mosi_q     <= 1'b0;
               rx_valid_q <= 1'b1;
               rx_data_q  <= rx_sh;
               tx_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven transfers with an rx scoreboard, plus
// back-to-back and mid-transfer reset sequences.
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int DW   = 8;
   localparam int NSS  = 5;
   localparam int DIVW = 8;
   localparam int SSW  = ss_w(NSS);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_ctrl_if #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DIVW)) bus();

   spi_master_ctrl #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DIVW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0]      mode;
      logic [DIVW-1:0] div;
      logic [DW-1:0]   data;
      logic [SSW-1:0]  sel;
      logic            wire_lb;
      logic            lb;
      logic [DW-1:0]   s_word;
      logic [DW-1:0]   exp_rx;
   } vec_t;

   typedef struct {
      logic [DW-1:0] rx;
      int            cyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   exp_t mon_e;
   int n_chk = 0, n_fail = 0, cyc = 0, ecnt = 0, e0 = 0, rel, idx;
   logic wire_lb = 1'b0;
   logic [DW-1:0] s_word = '0;
   logic slave_bit;

   always @(posedge clk) cyc <= cyc + 1;
   always @(bus.sclk) ecnt <= ecnt + 1;

   // Slave: cpha=0 presents MSB at select and shifts on trailing edges,
   // cpha=1 presents each bit on a leading edge.
   always_comb begin
      rel = ecnt - e0;
      idx = bus.cpha ? (rel + 1) / 2 - 1 : rel / 2;
      slave_bit = (idx >= 0 && idx < DW) ? s_word[DW-1-idx] : 1'b0;
   end
   assign bus.miso = wire_lb ? bus.mosi : slave_bit;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NSS-1:0] ss_exp(input int sel);
      logic [NSS-1:0] r;
      r = '1;
      if (sel < NSS) r[sel] = 1'b0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.rx_valid === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_rx_valid", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk("rx_data", 32'(bus.rx_data), 32'(mon_e.rx));
            chk("rx_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic run(input vec_t v, output int c);
      bus.cpol      = v.mode[1];
      bus.cpha      = v.mode[0];
      bus.clk_div   = v.div;
      bus.tx_data   = v.data;
      bus.tx_ss_sel = v.sel;
      wire_lb       = v.wire_lb;
      s_word        = v.s_word;
`ifdef SPI_MASTER_LOOPBACK_EN
      bus.loopback  = v.lb;
`endif
      repeat (2) @(posedge clk);
      #1;
      e0 = ecnt;
      bus.tx_valid = 1'b1;
      c = cyc;
      sb.push_back(exp_t'{v.exp_rx, c + 1 + (int'(v.div) + 1) * (2 * DW + 2)});
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      chk("setup_ss_n", 32'(bus.ss_n), 32'(ss_exp(int'(v.sel))));
      chk("setup_sclk", 32'(bus.sclk), 32'(v.mode[1]));
      chk("setup_busy", 32'(bus.busy), 32'd1);
      chk("setup_tx_ready", 32'(bus.tx_ready), 32'd0);
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (bus.busy === 1'b0) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) chk(name, 32'd0, 32'd1);
   endtask

   task automatic run_full(input vec_t v);
      int c;
      run(v, c);
      wait_idle("idle_timeout");
      chk("sclk_edges", ecnt - e0, 2 * DW);
      @(posedge clk);
      #1;
      chk("idle_sclk", 32'(bus.sclk), 32'(v.mode[1]));
      chk("idle_ss_n", 32'(bus.ss_n), 32'(ss_exp(NSS)));
      chk("idle_mosi", 32'(bus.mosi), 32'd0);
   endtask

   initial begin
      int c, seen;
      bus.tx_valid = 1'b0; bus.tx_data = '0; bus.tx_ss_sel = '0;
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      bus.loopback = 1'b0;
`endif
      vecs.push_back(vec_t'{SPI_MODE0, 8'd0, 8'hA5, 3'd0, 1'b1, 1'b0, 8'h00, 8'hA5});
      vecs.push_back(vec_t'{SPI_MODE1, 8'd3, 8'h96, 3'd1, 1'b0, 1'b0, 8'h3C, 8'h3C});
      vecs.push_back(vec_t'{SPI_MODE2, 8'd3, 8'h5A, 3'd2, 1'b0, 1'b0, 8'h3C, 8'h3C});
      vecs.push_back(vec_t'{SPI_MODE3, 8'd3, 8'hC3, 3'd3, 1'b0, 1'b0, 8'h3C, 8'h3C});
      vecs.push_back(vec_t'{SPI_MODE0, 8'd0, 8'h12, 3'd5, 1'b0, 1'b0, 8'h3C, 8'h3C});
      vecs.push_back(vec_t'{SPI_MODE3, 8'd0, 8'h6E, 3'd4, 1'b1, 1'b0, 8'h00, 8'h6E});
      vecs.push_back(vec_t'{SPI_MODE0, 8'd3, 8'h00, 3'd7, 1'b0, 1'b0, 8'hC5, 8'hC5});
`ifdef SPI_MASTER_LOOPBACK_EN
      vecs.push_back(vec_t'{SPI_MODE0, 8'd1, 8'h5A, 3'd0, 1'b0, 1'b1, 8'h00, 8'h5A});
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
      chk("rst_sclk", 32'(bus.sclk), 32'd0);
      chk("rst_mosi", 32'(bus.mosi), 32'd0);
      chk("rst_ss_n", 32'(bus.ss_n), 32'(ss_exp(NSS)));
      rst_n = 1'b1;

      foreach (vecs[i]) run_full(vecs[i]);

      // Back-to-back: tx_valid stays high across three words.
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0; bus.tx_ss_sel = '0;
      wire_lb = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.tx_data = 8'h01;
      bus.tx_valid = 1'b1;
      c = cyc;
      sb.push_back(exp_t'{8'h01, c + 19});
      sb.push_back(exp_t'{8'h80, c + 38});
      sb.push_back(exp_t'{8'hFF, c + 57});
      @(posedge clk);
      #1 bus.tx_data = 8'h80;
      repeat (17) @(posedge clk);
      #1 chk("b2b_ss_low_1", 32'(bus.ss_n), 32'(ss_exp(0)));
      @(posedge clk);
      #1 chk("b2b_ss_gap_1", 32'(bus.ss_n), 32'(ss_exp(NSS)));
      chk("b2b_ready_1", 32'(bus.tx_ready), 32'd1);
      @(posedge clk);
      #1 chk("b2b_ss_relow_1", 32'(bus.ss_n), 32'(ss_exp(0)));
      bus.tx_data = 8'hFF;
      repeat (18) @(posedge clk);
      #1 chk("b2b_ss_gap_2", 32'(bus.ss_n), 32'(ss_exp(NSS)));
      @(posedge clk);
      #1 chk("b2b_ss_relow_2", 32'(bus.ss_n), 32'(ss_exp(0)));
      bus.tx_valid = 1'b0;
      wait_idle("b2b_timeout");
      repeat (2) @(posedge clk);
      #1;

      // Reset after the seventh SCLK edge drops the transfer.
      run(vec_t'{SPI_MODE0, 8'd0, 8'hA5, 3'd1, 1'b1, 1'b0, 8'h00, 8'hA5}, c);
      for (int i = 0; i < 100 && (ecnt - e0) < 7; i++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_edge_reached", 32'(ecnt - e0 >= 7), 32'd1);
      rst_n = 1'b0;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      chk("mid_rst_ss_n", 32'(bus.ss_n), 32'(ss_exp(NSS)));
      chk("mid_rst_sclk", 32'(bus.sclk), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 if (bus.rx_valid !== 1'b0) seen++;
      end
      chk("mid_rst_no_rx_valid", seen, 0);
      run_full(vec_t'{SPI_MODE1, 8'd1, 8'h99, 3'd2, 1'b0, 1'b0, 8'h6B, 8'h6B});

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
